mem_port_arbiter: RTL

Sequencer that shares one single-port unified instruction/data memory between the pipeline's fetch stage (IF) and memory stage (MEM: lw/sw). It arbitrates requests, latches the address and data at grant, and drives the memory handshake across variable wait states. It returns read data with a one-cycle acknowledge and drives the pipeline stall line. The block sits between the IF/MEM stage logic and the memory model, downstream of the controller's memRead/memWrite decode.

---
 rtl/mem_port_arbiter.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port unified instruction/data memory between the fetch
// stage (IF) and the memory stage (MEM: lw/sw). Data requests win over fetch
// requests. Address, write data and write enable are latched at grant and held
// for the whole access. Read data is returned with a one-cycle acknowledge, and
// the pipeline stall line stays high until the request is acknowledged.
//
// Optional feature: define MEM_TIMEOUT_EN to abort an access that waits
// TIMEOUT cycles for i_mem_ready; the abort acks with zero data and sets the
// sticky o_err flag. Without the macro the block waits forever and o_err = 0.
//
// Ports:
//   i_clk        clock, all state changes on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_if_req     fetch request, held until o_if_ack
//   i_if_addr    fetch address
//   o_if_rdata   fetched instruction, valid while o_if_ack = 1
//   o_if_ack     one-cycle fetch completion pulse
//   i_d_read     data read request, held until o_d_ack
//   i_d_write    data write request, held until o_d_ack
//   i_d_addr     data address
//   i_d_wdata    store data
//   o_d_rdata    load data, valid while o_d_ack = 1
//   o_d_ack      one-cycle data completion pulse
//   o_mem_en     memory access active
//   o_mem_we     memory write strobe, qualified by o_mem_en
//   o_mem_addr   memory address
//   o_mem_wdata  memory write data
//   i_mem_rdata  memory read data, sampled when i_mem_ready = 1
//   i_mem_ready  memory completion, ignored while o_mem_en = 0
//   o_stall      pipeline hold (combinational)
//   o_err        sticky timeout flag
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic [DW-1:0] o_if_rdata,
  output logic          o_if_ack,
  input  logic          i_d_read,
  input  logic          i_d_write,
  input  logic [AW-1:0] i_d_addr,
  input  logic [DW-1:0] i_d_wdata,
  output logic [DW-1:0] o_d_rdata,
  output logic          o_d_ack,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  input  logic          i_mem_ready,
  output logic          o_stall,
  output logic          o_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_mem_we;
  logic          r_is_data;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_err;

  logic          w_d_req;
  logic          w_busy;
  logic          w_grant_d;
  logic          w_grant_i;
  logic          w_capture;
  logic          w_abort;
  logic          w_timeout;
  logic          w_d_ack;
  logic          w_if_ack;

  assign w_d_req = i_d_read | i_d_write;
  assign w_busy  = (r_state == DATA) || (r_state == INST);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and one-cycle control strobes
  always_comb begin
    w_next_state = r_state;
    w_grant_d    = 1'b0;
    w_grant_i    = 1'b0;
    w_capture    = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_d_req) begin
          w_next_state = DATA;
          w_grant_d    = 1'b1;
        end else if (i_if_req) begin
          w_next_state = INST;
          w_grant_i    = 1'b1;
        end
      end
      DATA, INST: begin
        if (i_mem_ready) begin
          w_next_state = DONE;
          w_capture    = 1'b1;
        end else if (w_timeout) begin
          w_next_state = DONE;
          w_abort      = 1'b1;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Access parameters are latched at grant so later request changes cannot
  // disturb an access in flight. A simultaneous read+write counts as a write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_is_data   <= 1'b0;
    end else if (w_grant_d) begin
      r_mem_addr  <= i_d_addr;
      r_mem_wdata <= i_d_wdata;
      r_mem_we    <= i_d_write;
      r_is_data   <= 1'b1;
    end else if (w_grant_i) begin
      r_mem_addr  <= i_if_addr;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_is_data   <= 1'b0;
    end
  end

  // Read data holders keep their value between acks; writes leave d_rdata
  // alone and an aborted read returns zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else if (w_capture || w_abort) begin
      if (!r_is_data) begin
        r_if_rdata <= w_capture ? i_mem_rdata : '0;
      end else if (!r_mem_we) begin
        r_d_rdata  <= w_capture ? i_mem_rdata : '0;
      end
    end
  end

  // Sticky error flag, only ever set by a timeout abort
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else if (w_abort) begin
      r_err <= 1'b1;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_wait_cnt;

  // Counts wait cycles of the current access; the abort fires on the edge
  // that would bring the count to TIMEOUT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_grant_d || w_grant_i) begin
      r_wait_cnt <= '0;
    end else if (w_busy && !i_mem_ready) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign w_timeout = w_busy && !i_mem_ready && (r_wait_cnt == CW'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  assign w_d_ack  = (r_state == DONE) &&  r_is_data;
  assign w_if_ack = (r_state == DONE) && !r_is_data;

  assign o_mem_en    = w_busy;
  assign o_mem_we    = w_busy & r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_if_rdata  = r_if_rdata;
  assign o_d_rdata   = r_d_rdata;
  assign o_if_ack    = w_if_ack;
  assign o_d_ack     = w_d_ack;
  assign o_err       = r_err;

  assign o_stall = (w_d_req & ~w_d_ack) | (i_if_req & ~w_if_ack);

endmodule
